uart_host_ctrl: RTL and testbench

Sequencer that owns the UART register interface (WRITES/READS strobes, UDI/UDO byte buses) on behalf of a byte-stream client. After reset it programs the UART configuration register, then polls the UART status byte and moves bytes between two internal FIFOs and the UART: received bytes go to an RX FIFO, and queued bytes from a TX FIFO go to the transmitter. It sits between the UART and the system-side producer/consumer, so no other logic drives the UART strobes.

---
 rtl/uart_host_ctrl.sv | 177 +++++++++++++++++
 tb/tb_uart_host_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_host_ctrl.sv
// UART register-interface sequencer: programs the UART config, then polls status and moves
// bytes between the UART data register and an internal TX FIFO / RX FIFO pair.
module uart_host_ctrl #(
  parameter logic [7:0]  CFG_INIT = 8'h08,
  parameter int unsigned AW       = 4,
  parameter int unsigned SETTLE   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_wr,
  input  logic [7:0] cfg_data,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       err_clr,
  output logic [2:0] err_flags,
  output logic       cfg_busy,
  output logic [7:0] writes,
  output logic [7:0] reads,
  output logic [7:0] udi,
  input  logic [7:0] udo
);

  localparam int unsigned   Depth      = 1 << AW;
  localparam logic [3:0]    SettleLast = 4'(SETTLE - 1);
  localparam logic [AW-1:0] PtrOne     = 1;
  localparam logic [AW:0]   CntOne     = 1;

  typedef enum logic [2:0] {StCfg, StPoll, StRdd, StWrd, StSet} state_e;

  state_e     state_q, state_d;
  logic [3:0] set_cnt_q, set_cnt_d;
  logic [7:0] cfg_reg_q, cfg_reg_d;
  logic       cfg_pend_q, cfg_pend_d;
  logic [2:0] err_q, err_d;

  logic [7:0]    tx_mem [Depth];
  logic [7:0]    rx_mem [Depth];
  logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [AW:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          tx_empty, tx_full, rx_empty, rx_full;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = tx_cnt_q[AW];
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = rx_cnt_q[AW];

  // Client-facing handshakes are held low while reset is asserted.
  assign tx_ready = !rst && !tx_full;
  assign rx_valid = !rst && !rx_empty;
  assign rx_data  = rx_valid ? rx_mem[rx_rd_q] : 8'h00;

  assign tx_push = tx_valid && tx_ready;
  assign tx_pop  = !rst && (state_q == StWrd);
  assign rx_push = !rst && (state_q == StRdd);
  assign rx_pop  = rx_valid && rx_ready;

  assign err_flags = err_q;
  assign cfg_busy  = cfg_pend_q;

  always_comb begin
    state_d    = state_q;
    set_cnt_d  = '0;
    cfg_reg_d  = cfg_reg_q;
    cfg_pend_d = cfg_pend_q;
    err_d      = err_q;
    unique case (state_q)
      StCfg: state_d = StPoll;
      StPoll: begin
        // Reconfigure only once the TX FIFO has drained; queued bytes keep flowing meanwhile.
        if (cfg_pend_q && udo[1] && tx_empty) begin
          state_d = StCfg;
        end else if (udo[0] && !rx_full) begin
          state_d = StRdd;
        end else if (udo[1] && !tx_empty) begin
          state_d = StWrd;
        end
      end
      StRdd, StWrd: state_d = StSet;
      StSet: begin
        if (set_cnt_q == SettleLast) begin
          state_d = StPoll;
        end else begin
          set_cnt_d = set_cnt_q + 4'd1;
        end
      end
      default: state_d = StCfg;
    endcase

    if (state_q == StCfg) cfg_pend_d = 1'b0;
    if (cfg_wr) begin
      cfg_pend_d = 1'b1;
      cfg_reg_d  = cfg_data;
    end

    if (err_clr) begin
      err_d = '0;
    end else if (state_q == StPoll) begin
      err_d = err_q | udo[4:2];
    end
  end

  always_comb begin
    tx_wr_d  = tx_push ? tx_wr_q + PtrOne : tx_wr_q;
    tx_rd_d  = tx_pop ? tx_rd_q + PtrOne : tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + CntOne;
    if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CntOne;

    rx_wr_d  = rx_push ? rx_wr_q + PtrOne : rx_wr_q;
    rx_rd_d  = rx_pop ? rx_rd_q + PtrOne : rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + CntOne;
    if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CntOne;
  end

  // Strobes are Moore outputs of the state register, forced idle during reset.
  always_comb begin
    writes = '0;
    reads  = '0;
    udi    = '0;
    if (!rst) begin
      unique case (state_q)
        StCfg: begin
          writes[6] = 1'b1;
          udi       = cfg_reg_q;
        end
        StPoll: reads[1] = 1'b1;
        StRdd:  reads[0] = 1'b1;
        StWrd: begin
          writes[0] = 1'b1;
          udi       = tx_mem[tx_rd_q];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StCfg;
      set_cnt_q  <= '0;
      cfg_reg_q  <= CFG_INIT;
      cfg_pend_q <= 1'b0;
      err_q      <= '0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_cnt_q   <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      set_cnt_q  <= set_cnt_d;
      cfg_reg_q  <= cfg_reg_d;
      cfg_pend_q <= cfg_pend_d;
      err_q      <= err_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= tx_data;
    if (rx_push) rx_mem[rx_wr_q] <= udo;
  end

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Scoreboard bench for uart_host_ctrl: a queue-based UART/client model predicts every data
// write, config write and delivered RX byte; a negedge monitor compares as the DUT acts.
module tb_uart_host_ctrl;

  localparam logic [7:0]  CfgInit = 8'hB8;
  localparam int unsigned Aw      = 4;
  localparam int unsigned Settle  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_wr = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [2:0] err_flags;
  logic       cfg_busy;
  logic [7:0] writes;
  logic [7:0] reads;
  logic [7:0] udi;
  logic [7:0] udo;

  // UART line model controls
  logic       tx_rdy_in = 1'b0;
  logic [2:0] err_inj = 3'b000;
  logic       line_in_v = 1'b0;
  logic [7:0] line_in_d = 8'h00;
  logic       line_has = 1'b0;
  logic [7:0] line_head = 8'h00;

  logic [7:0] line_q[$];
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];
  logic [7:0] cfg_exp[$];
  logic [7:0] ev_log[$];
  int         wr_cyc[$];

  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   rd_pulses = 0;
  logic consume_q = 1'b0;
  logic cfg_pend_m = 1'b0;

  always #5 clk = ~clk;

  assign udo = reads[1] ? {3'b000, err_inj, tx_rdy_in, line_has} :
               reads[0] ? line_head : 8'h00;

  uart_host_ctrl #(
    .CFG_INIT (CfgInit),
    .AW       (Aw),
    .SETTLE   (Settle)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_wr    (cfg_wr),
    .cfg_data  (cfg_data),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .err_clr   (err_clr),
    .err_flags (err_flags),
    .cfg_busy  (cfg_busy),
    .writes    (writes),
    .reads     (reads),
    .udi       (udi),
    .udo       (udo)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  task automatic monitor_cycle();
    cyc++;
    if (rst) begin
      line_q.delete();
      rx_exp.delete();
      tx_exp.delete();
      cfg_exp.delete();
      cfg_exp.push_back(CfgInit);
      cfg_pend_m = 1'b0;
      consume_q  = 1'b0;
    end else begin
      chk("cfg_busy", 32'(cfg_busy), 32'(cfg_pend_m));
      if (consume_q && line_q.size() != 0) void'(line_q.pop_front());
      consume_q = 1'b0;

      if (writes == 8'h01) begin
        ev_log.push_back(8'h01);
        wr_cyc.push_back(cyc);
        chk("tx_write_expected", 32'(tx_exp.size() != 0), 32'd1);
        if (tx_exp.size() != 0) chk("tx_byte", 32'(udi), 32'(tx_exp.pop_front()));
      end else if (writes == 8'h40) begin
        ev_log.push_back(8'h40);
        chk("cfg_write_expected", 32'(cfg_exp.size() != 0), 32'd1);
        if (cfg_exp.size() != 0) chk("cfg_byte", 32'(udi), 32'(cfg_exp.pop_front()));
        cfg_pend_m = 1'b0;
      end else begin
        chk("writes_legal", 32'(writes), 32'd0);
        chk("udi_idle", 32'(udi), 32'd0);
      end

      if (reads == 8'h01) begin
        ev_log.push_back(8'hD0);
        rd_pulses++;
        consume_q = 1'b1;
      end else if (reads != 8'h02) begin
        chk("reads_legal", 32'(reads), 32'd0);
      end

      if (rx_valid && rx_ready) begin
        chk("rx_pop_expected", 32'(rx_exp.size() != 0), 32'd1);
        if (rx_exp.size() != 0) chk("rx_byte", 32'(rx_data), 32'(rx_exp.pop_front()));
      end
      if (tx_valid && tx_ready) tx_exp.push_back(tx_data);
      if (cfg_wr) begin
        if (cfg_pend_m && cfg_exp.size() != 0) cfg_exp[cfg_exp.size() - 1] = cfg_data;
        else cfg_exp.push_back(cfg_data);
        cfg_pend_m = 1'b1;
      end
      if (line_in_v) begin
        line_q.push_back(line_in_d);
        rx_exp.push_back(line_in_d);
      end
    end
    line_has  = (line_q.size() != 0);
    line_head = line_has ? line_q[0] : 8'h00;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      monitor_cycle();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  task automatic send_tx(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    tx_valid = 1'b1;
    tx_data  = b;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("tx_accept_timeout", 32'(ok), 32'd1);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic add_line(input logic [7:0] b);
    line_in_v = 1'b1;
    line_in_d = b;
    tick();
    line_in_v = 1'b0;
  endtask

  task automatic wait_ev(input int n, input int limit);
    for (int i = 0; i < limit && ev_log.size() < n; i++) samp();
    chk("event_timeout", 32'(ev_log.size() >= n), 32'd1);
  endtask

  task automatic wait_drained(input int limit);
    for (int i = 0; i < limit && (tx_exp.size() != 0 || rx_exp.size() != 0 || line_q.size() != 0);
         i++) samp();
    chk("drain_tx", 32'(tx_exp.size()), 32'd0);
    chk("drain_rx", 32'(rx_exp.size()), 32'd0);
    chk("drain_line", 32'(line_q.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int base;
    int rd_base;

    // Reset bring-up
    repeat (3) @(posedge clk);
    samp();
    chk("rst_writes", 32'(writes), 32'd0);
    chk("rst_reads", 32'(reads), 32'd0);
    chk("rst_udi", 32'(udi), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_err", 32'(err_flags), 32'd0);
    chk("rst_cfg_busy", 32'(cfg_busy), 32'd0);
    tick();
    rst = 1'b0;
    samp();
    chk("boot_writes", 32'(writes), 32'h40);
    chk("boot_udi", 32'(udi), 32'(CfgInit));
    chk("boot_tx_ready", 32'(tx_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      samp();
      chk("boot_poll", 32'(reads), 32'h02);
    end
    tick();

    // TX drain with even spacing
    tx_rdy_in = 1'b1;
    base = wr_cyc.size();
    send_tx(8'hA1);
    send_tx(8'hA2);
    send_tx(8'hA3);
    for (int i = 0; i < 200 && wr_cyc.size() < base + 3; i++) samp();
    chk("tx_three_writes", 32'(wr_cyc.size() >= base + 3), 32'd1);
    if (wr_cyc.size() >= base + 3) begin
      chk("tx_spacing_1", 32'(wr_cyc[base + 1] - wr_cyc[base]), 32'(2 + Settle));
      chk("tx_spacing_2", 32'(wr_cyc[base + 2] - wr_cyc[base + 1]), 32'(2 + Settle));
    end
    tick();

    // RX takes priority over a queued TX byte
    tx_rdy_in = 1'b0;
    send_tx(8'h77);
    repeat (3) tick();
    base = ev_log.size();
    tx_rdy_in = 1'b1;
    add_line(8'h5C);
    wait_ev(base + 1, 100);
    if (ev_log.size() > base) chk("rx_before_tx", 32'(ev_log[base]), 32'hD0);
    chk("rx_valid_in_rdd", 32'(rx_valid), 32'd0);
    samp();
    chk("rx_valid_after_rdd", 32'(rx_valid), 32'd1);
    chk("rx_data_after_rdd", 32'(rx_data), 32'h5C);
    tick();
    rx_ready = 1'b1;
    wait_drained(200);
    tick();

    // RX FIFO full: no data read, overrun reported
    rx_ready  = 1'b0;
    tx_rdy_in = 1'b0;
    rd_base   = rd_pulses;
    for (int i = 0; i < 17; i++) add_line(8'($urandom));
    for (int i = 0; i < 300 && rd_pulses < rd_base + 16; i++) samp();
    tick();
    err_inj = 3'b100;
    repeat (20) tick();
    samp();
    chk("full_reads", 32'(rd_pulses - rd_base), 32'd16);
    chk("full_ovf", 32'(err_flags), 32'b100);
    chk("full_rx_valid", 32'(rx_valid), 32'd1);
    tick();
    err_inj = 3'b000;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    samp();
    chk("err_cleared", 32'(err_flags), 32'd0);
    tick();
    rx_ready = 1'b1;
    wait_drained(500);
    tick();

    // Reconfigure with TX bytes queued
    rx_ready = 1'b0;
    send_tx(8'h31);
    send_tx(8'h32);
    base = ev_log.size();
    cfg_wr   = 1'b1;
    cfg_data = 8'h5C;
    tick();
    cfg_wr = 1'b0;
    samp();
    chk("cfg_busy_rise", 32'(cfg_busy), 32'd1);
    tick();
    tx_rdy_in = 1'b1;
    wait_ev(base + 3, 200);
    if (ev_log.size() >= base + 3) begin
      chk("recfg_order_0", 32'(ev_log[base]), 32'h01);
      chk("recfg_order_1", 32'(ev_log[base + 1]), 32'h01);
      chk("recfg_order_2", 32'(ev_log[base + 2]), 32'h40);
    end
    samp();
    chk("cfg_busy_fall", 32'(cfg_busy), 32'd0);
    tick();

    // Reset during SET with RX bytes buffered
    tx_rdy_in = 1'b0;
    rd_base   = rd_pulses;
    for (int i = 0; i < 5; i++) add_line(8'($urandom));
    for (int i = 0; i < 200 && rd_pulses < rd_base + 5; i++) samp();
    chk("midrst_reads", 32'(rd_pulses - rd_base), 32'd5);
    tick();
    rst = 1'b1;
    samp();
    chk("midrst_rx_valid", 32'(rx_valid), 32'd0);
    tick();
    samp();
    chk("midrst_rx_valid_2", 32'(rx_valid), 32'd0);
    tick();
    rst = 1'b0;
    samp();
    chk("midrst_cfg_writes", 32'(writes), 32'h40);
    chk("midrst_cfg_udi", 32'(udi), 32'(CfgInit));
    chk("midrst_rx_empty", 32'(rx_valid), 32'd0);
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      tx_valid  = ($urandom_range(0, 2) == 0);
      tx_data   = 8'($urandom);
      rx_ready  = ($urandom_range(0, 1) == 1);
      tx_rdy_in = ($urandom_range(0, 3) != 0);
      line_in_v = (line_q.size() < 2) && ($urandom_range(0, 3) == 0);
      line_in_d = 8'($urandom);
      tick();
    end
    tx_valid  = 1'b0;
    line_in_v = 1'b0;
    rx_ready  = 1'b1;
    tx_rdy_in = 1'b1;
    wait_drained(3000);
    samp();
    chk("final_rx_valid", 32'(rx_valid), 32'd0);
    chk("final_cfg_queue", 32'(cfg_exp.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
